sample_scheduler: RTL

Per-sample sequencer for the equalizer datapath. It generates the sample-rate conversion start for the ADC SPI master, then forwards the ADC ready to the filter bank as a one-cycle enable. It waits out the filter latency and loads the DAC master. Band selection from the PS/2 path is committed only at sample boundaries, so no output sample mixes two mux settings.

---
 rtl/sample_scheduler_pkg.sv | 19 +
 rtl/sample_tick_gen.sv | 29 ++
 rtl/sample_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sample_scheduler_pkg.sv
// Shared types and constants for the per-sample sequencer and its period generator.
package sample_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FILT = 2'd2,
        LOAD = 2'd3
    } sched_state_t;

    localparam int SAMPLE_DIV_DEF = 2268;
    localparam int SEL_W_DEF      = 2;

    localparam logic [SEL_W_DEF-1:0] SEL_BYPASS = 2'd0;
    localparam logic [SEL_W_DEF-1:0] SEL_LOW    = 2'd1;
    localparam logic [SEL_W_DEF-1:0] SEL_MID    = 2'd2;
    localparam logic [SEL_W_DEF-1:0] SEL_HIGH   = 2'd3;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running period counter; tick is high for the last cycle of every period.
module sample_tick_gen
    import sample_scheduler_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/sample_scheduler.sv
// Per-sample sequencer: ADC start, filter enable, DAC load, sample-aligned band select
// commit and sticky overrun/timeout flags.
module sample_scheduler
    import sample_scheduler_pkg::*;
#(
    parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF,
    parameter int FILT_LAT    = 24,
    parameter int ADC_TIMEOUT = 400,
    parameter int SEL_W       = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adc_ready,
    input  logic             dac_busy,
    input  logic [SEL_W-1:0] sel_req,
    input  logic             sel_req_valid,
    input  logic             clr_err,
    output logic             adc_start,
    output logic             filt_en,
    output logic             dac_load,
    output logic [SEL_W-1:0] sel_out,
    output logic [15:0]      sample_cnt,
    output logic             err_overrun,
    output logic             err_timeout
);

    localparam int TO_W  = $clog2(ADC_TIMEOUT + 1);
    localparam int LAT_W = $clog2(FILT_LAT + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ADC_TIMEOUT - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(FILT_LAT - 1);

    sched_state_t     state;
    logic [TO_W-1:0]  to_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic [SEL_W-1:0] pend_sel;
    logic             pend_vld;
    logic             tick;
    logic             ovr_evt;
    logic             to_evt;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // A tick that finds the sequence still busy is dropped, not queued.
    assign ovr_evt = tick && (state != IDLE);
    assign to_evt  = (state == CONV) && !adc_ready && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            to_cnt      <= '0;
            lat_cnt     <= '0;
            adc_start   <= 1'b0;
            filt_en     <= 1'b0;
            dac_load    <= 1'b0;
            sel_out     <= '0;
            pend_sel    <= '0;
            pend_vld    <= 1'b0;
            sample_cnt  <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            adc_start <= 1'b0;
            filt_en   <= 1'b0;
            dac_load  <= 1'b0;

            case (state)
                IDLE: begin
                    if (tick) begin
                        adc_start <= 1'b1;
                        to_cnt    <= '0;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    if (adc_ready) begin
                        filt_en <= 1'b1;
                        lat_cnt <= '0;
                        state   <= FILT;
                    end else if (to_cnt == TO_LAST) begin
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                FILT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state <= LOAD;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (!dac_busy) begin
                        dac_load   <= 1'b1;
                        sample_cnt <= sample_cnt + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Commit rides on the registered dac_load, so sel_out changes one edge later;
            // a strobe landing on that cycle stays pending for the next sample.
            if (dac_load && pend_vld) begin
                sel_out <= pend_sel;
            end
            if (sel_req_valid) begin
                pend_sel <= sel_req;
                pend_vld <= 1'b1;
            end else if (dac_load) begin
                pend_vld <= 1'b0;
            end

            if (ovr_evt) begin
                err_overrun <= 1'b1;
            end else if (clr_err) begin
                err_overrun <= 1'b0;
            end
            if (to_evt) begin
                err_timeout <= 1'b1;
            end else if (clr_err) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule
